// File: rtl/alu_console.sv
// Press-to-execute ALU console: debounced buttons, latched operands, registered
// NZCV result, and a scanned active-low hex display of the result.
module alu_console #(
    parameter int WIDTH           = 8,
    parameter int DIGITS          = WIDTH / 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SCAN_DIV        = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  SwA,
    input  logic [WIDTH-1:0]  SwB,
    input  logic [2:0]        BtnOp,
    input  logic              BtnExec,
    output logic              Busy,
    output logic [3:0]        LedFlags,
    output logic [DIGITS-1:0] DigitEn,
    output logic [6:0]        SevenSegResult
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {IDLE, LATCH, EXEC, HOLD} state_t;

    state_t             state, state_nx;
    logic [WIDTH-1:0]   swa_s1, swa_s2, swb_s1, swb_s2;
    logic [3:0]         btn_s1, btn_s2, btn_lvl;
    logic [DW-1:0]      db_cnt [4];
    logic               exec_prev, armed, exec_pressed, exec_event;
    logic [WIDTH-1:0]   a_p0, b_p0, result_p1;
    logic [2:0]         op_p0;
    logic [3:0]         flags_p1;
    logic [WIDTH+3:0]   alu_out;
    logic [SW-1:0]      scan_cnt;
    logic [IW-1:0]      dig_idx, dig_nx;
    logic [DIGITS-1:0]  en_on;
    logic [6:0]         seg_on;
    logic [3:0]         nib_nx;

    // Returns {N, Z, C, V, result}.
    function automatic logic [WIDTH+3:0] alu_eval(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic [2:0]       op);
        logic [WIDTH:0]   wide;
        logic [WIDTH-1:0] r;
        logic             c, v;
        wide = '0;
        r    = a;
        c    = 1'b0;
        v    = 1'b0;
        case (op)
            3'd0: begin
                wide = {1'b0, a} + {1'b0, b};
                r    = wide[WIDTH-1:0];
                c    = wide[WIDTH];
                v    = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            3'd1: begin
                wide = {1'b0, a} - {1'b0, b};
                r    = wide[WIDTH-1:0];
                c    = ~wide[WIDTH];
                v    = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: begin
                r = {a[WIDTH-2:0], 1'b0};
                c = a[WIDTH-1];
            end
            3'd6: begin
                r = {1'b0, a[WIDTH-1:1]};
                c = a[0];
            end
            default: r = a;
        endcase
        return {r[WIDTH-1], (r == '0), c, v, r};
    endfunction

    // Active-high segments {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_font(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;
            4'h1: return 7'h06;
            4'h2: return 7'h5B;
            4'h3: return 7'h4F;
            4'h4: return 7'h66;
            4'h5: return 7'h6D;
            4'h6: return 7'h7D;
            4'h7: return 7'h07;
            4'h8: return 7'h7F;
            4'h9: return 7'h6F;
            4'hA: return 7'h77;
            4'hB: return 7'h7C;
            4'hC: return 7'h39;
            4'hD: return 7'h5E;
            4'hE: return 7'h79;
            default: return 7'h71;
        endcase
    endfunction

    // Input synchronizers; bit 3 of the button bank is exec.
    always_ff @(posedge clk) begin
        swa_s1 <= SwA;
        swa_s2 <= swa_s1;
        swb_s1 <= SwB;
        swb_s2 <= swb_s1;
        btn_s1 <= {BtnExec, BtnOp};
        btn_s2 <= btn_s1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_lvl <= '1;
            for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (btn_s2[i] != btn_lvl[i]) begin
                    if (db_cnt[i] == DW'(DEBOUNCE_CYCLES)) begin
                        btn_lvl[i] <= btn_s2[i];
                        db_cnt[i]  <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DW'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // armed stays low after reset until exec is seen released, so a button
    // held through reset cannot fire an operation.
    assign exec_pressed = ~btn_lvl[3];
    assign exec_event   = armed & exec_pressed & ~exec_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            exec_prev <= 1'b0;
            armed     <= 1'b0;
            state     <= IDLE;
        end else begin
            exec_prev <= exec_pressed;
            if (btn_lvl[3] && btn_s2[3]) armed <= 1'b1;
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (exec_event) state_nx = LATCH;
            LATCH:   state_nx = EXEC;
            EXEC:    state_nx = HOLD;
            HOLD:    if (!exec_pressed) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign Busy = (state != IDLE);

    // Stage p0: operand/op capture
    always_ff @(posedge clk) begin
        if (state == LATCH) begin
            a_p0  <= swa_s2;
            b_p0  <= swb_s2;
            op_p0 <= ~btn_lvl[2:0];
        end
    end

    assign alu_out = alu_eval(a_p0, b_p0, op_p0);

    // Stage p1: registered result and flags
    always_ff @(posedge clk) begin
        if (reset) begin
            result_p1 <= '0;
            flags_p1  <= 4'b0100;
        end else if (state == EXEC) begin
            result_p1 <= alu_out[WIDTH-1:0];
            flags_p1  <= alu_out[WIDTH+3:WIDTH];
        end
    end

    assign LedFlags = flags_p1;

    assign dig_nx = (dig_idx == IW'(DIGITS - 1)) ? '0 : dig_idx + IW'(1);
    assign nib_nx = 4'(result_p1 >> {dig_nx, 2'b00});

    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt <= '0;
            dig_idx  <= '0;
            en_on    <= DIGITS'(1);
            seg_on   <= 7'h3F;
        end else if (scan_cnt == SW'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            dig_idx  <= dig_nx;
            en_on    <= DIGITS'(1) << dig_nx;
            seg_on   <= hex_font(nib_nx);
        end else begin
            scan_cnt <= scan_cnt + SW'(1);
        end
    end

    assign DigitEn        = ~en_on;
    assign SevenSegResult = ~seg_on;

endmodule

// File: tb/tb_alu_console.sv
// Self-checking bench for alu_console: timing sequences, a vector table and
// random operations compared against an arithmetic reference model.
module tb_alu_console;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] SwA, SwB;
    logic [2:0] BtnOp;
    logic       BtnExec;
    logic       Busy;
    logic [3:0] LedFlags;
    logic [1:0] DigitEn;
    logic [6:0] SevenSegResult;

    int checks   = 0;
    int failures = 0;

    alu_console #(.WIDTH(8), .DIGITS(2), .DEBOUNCE_CYCLES(D), .SCAN_DIV(16)) dut (
        .clk(clk), .reset(reset), .SwA(SwA), .SwB(SwB), .BtnOp(BtnOp),
        .BtnExec(BtnExec), .Busy(Busy), .LedFlags(LedFlags),
        .DigitEn(DigitEn), .SevenSegResult(SevenSegResult)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic [7:0] res;
        logic [3:0] flags;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: NZCV and result from plain integer arithmetic.
    function automatic logic [11:0] model(input int a, input int b, input int op);
        int r, c, v, sa, sb, s;
        logic [3:0] f;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        c = 0;
        v = 0;
        case (op)
            0: begin
                s = a + b; r = s % 256; c = (s > 255) ? 1 : 0;
                s = sa + sb; v = (s > 127 || s < -128) ? 1 : 0;
            end
            1: begin
                r = (a - b + 256) % 256; c = (a >= b) ? 1 : 0;
                s = sa - sb; v = (s > 127 || s < -128) ? 1 : 0;
            end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: begin r = (a * 2) % 256; c = (a >= 128) ? 1 : 0; end
            6: begin r = a / 2; c = a % 2; end
            default: r = a;
        endcase
        f = {(r >= 128), (r == 0), (c != 0), (v != 0)};
        return {f, 8'(r)};
    endfunction

    function automatic int decode(input logic [6:0] s);
        case (s)
            7'b1000000: return 0;
            7'b1111001: return 1;
            7'b0100100: return 2;
            7'b0110000: return 3;
            7'b0011001: return 4;
            7'b0010010: return 5;
            7'b0000010: return 6;
            7'b1111000: return 7;
            7'b0000000: return 8;
            7'b0010000: return 9;
            7'b0001000: return 10;
            7'b0000011: return 11;
            7'b1000110: return 12;
            7'b0100001: return 13;
            7'b0000110: return 14;
            7'b0001110: return 15;
            default:    return -1;
        endcase
    endfunction

    // Watches two full refresh periods and rebuilds the displayed byte.
    task automatic read_display(output int val);
        int nib [2];
        logic [1:0] m;
        nib[0] = -1;
        nib[1] = -1;
        for (int c = 0; c < 64; c++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                m = ~(2'b01 << i);
                if (DigitEn === m) nib[i] = decode(SevenSegResult);
            end
        end
        val = (nib[0] < 0 || nib[1] < 0) ? -1 : nib[1] * 16 + nib[0];
    endtask

    task automatic wait_busy(input logic lvl, input int bound, input string name);
        int n = 0;
        while (Busy !== lvl && n < bound) begin
            tick();
            n++;
        end
        check(name, 32'(Busy), 32'(lvl));
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                          output logic [3:0] fl, output int disp);
        SwA   = a;
        SwB   = b;
        BtnOp = ~op;
        repeat (12) tick();
        BtnExec = 1'b0;
        wait_busy(1'b1, 20, "busy_rise");
        repeat (4) tick();
        BtnExec = 1'b1;
        wait_busy(1'b0, 20, "busy_fall");
        fl = LedFlags;
        read_display(disp);
        BtnOp = 3'b111;
    endtask

    initial begin
        vec_t       vecs [11];
        logic [3:0] fl;
        int         disp, rises, busy_low, any_busy, last_t, t, nchg;
        int         iv [4];
        logic       pb;
        logic [1:0] prev_en;
        logic [11:0] exp;

        vecs[0]  = '{8'h7F, 8'h01, 3'd0, 8'h80, 4'b1001};
        vecs[1]  = '{8'h05, 8'h05, 3'd1, 8'h00, 4'b0110};
        vecs[2]  = '{8'h03, 8'h05, 3'd1, 8'hFE, 4'b1000};
        vecs[3]  = '{8'hFF, 8'h01, 3'd0, 8'h00, 4'b0110};
        vecs[4]  = '{8'hF0, 8'h3C, 3'd2, 8'h30, 4'b0000};
        vecs[5]  = '{8'hF0, 8'h0F, 3'd3, 8'hFF, 4'b1000};
        vecs[6]  = '{8'hAA, 8'hFF, 3'd4, 8'h55, 4'b0000};
        vecs[7]  = '{8'h01, 8'h9C, 3'd6, 8'h00, 4'b0110};
        vecs[8]  = '{8'h80, 8'h12, 3'd7, 8'h80, 4'b1000};
        vecs[9]  = '{8'h80, 8'h01, 3'd1, 8'h7F, 4'b0011};
        vecs[10] = '{8'hC4, 8'h00, 3'd5, 8'h88, 4'b1010};

        reset   = 1'b1;
        SwA     = 8'h00;
        SwB     = 8'h00;
        BtnOp   = 3'b111;
        BtnExec = 1'b1;
        repeat (3) tick();
        check("rst_flags", 32'(LedFlags), 32'h4);
        check("rst_digiten", 32'(DigitEn), 32'h2);
        check("rst_seg", 32'(SevenSegResult), 32'h40);
        check("rst_busy", 32'(Busy), 32'h0);
        reset = 1'b0;

        // Press latency on the overflowing add
        SwA = 8'h7F;
        SwB = 8'h01;
        BtnOp = 3'b111;
        repeat (12) tick();
        BtnExec = 1'b0;
        for (int n = 1; n <= D + 6; n++) begin
            tick();
            if (n == D + 3) check("lat_busy_pre", 32'(Busy), 32'h0);
            if (n == D + 4) check("lat_busy_rise", 32'(Busy), 32'h1);
            if (n == D + 5) check("lat_flags_pre", 32'(LedFlags), 32'h4);
            if (n == D + 6) check("lat_flags_new", 32'(LedFlags), 32'h9);
        end
        repeat (3) tick();
        BtnExec = 1'b1;
        wait_busy(1'b0, 20, "lat_busy_fall");
        read_display(disp);
        check("lat_display", 32'(disp), 32'h80);

        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].op, fl, disp);
            check($sformatf("vec%0d_flags", i), 32'(fl), 32'(vecs[i].flags));
            check($sformatf("vec%0d_result", i), 32'(disp), 32'(vecs[i].res));
        end

        // Short exec bounces must not start an operation
        any_busy = 0;
        for (int rep = 0; rep < 2; rep++) begin
            for (int len = 1; len < D; len++) begin
                BtnExec = 1'b0;
                repeat (len) begin tick(); if (Busy) any_busy++; end
                BtnExec = 1'b1;
                tick();
                if (Busy) any_busy++;
            end
        end
        repeat (20) begin tick(); if (Busy) any_busy++; end
        check("bounce_no_busy", 32'(any_busy), 32'h0);
        check("bounce_flags", 32'(LedFlags), 32'(vecs[10].flags));

        // Long hold executes exactly once
        SwA = 8'h21; SwB = 8'h12; BtnOp = ~3'd0;
        repeat (12) tick();
        BtnExec = 1'b0;
        rises = 0;
        pb = Busy;
        repeat (200) begin
            tick();
            if (Busy && !pb) rises++;
            pb = Busy;
        end
        check("hold_rises", 32'(rises), 32'h1);
        check("hold_busy", 32'(Busy), 32'h1);
        BtnExec = 1'b1;
        wait_busy(1'b0, 20, "hold_busy_fall");
        check("hold_flags", 32'(LedFlags), 32'(model(8'h21, 8'h12, 0) >> 8));

        // Switch/op changes after LATCH and a re-press glitch in HOLD are ignored
        SwA = 8'h10; SwB = 8'h01; BtnOp = ~3'd0;
        repeat (12) tick();
        BtnExec = 1'b0;
        wait_busy(1'b1, 20, "iso_busy_rise");
        SwA = 8'hFF; SwB = 8'hFF; BtnOp = ~3'd4;
        repeat (10) tick();
        BtnExec = 1'b1;
        repeat (D - 1) tick();
        BtnExec = 1'b0;
        busy_low = 0;
        repeat (20) begin tick(); if (!Busy) busy_low++; end
        check("iso_stay_hold", 32'(busy_low), 32'h0);
        BtnExec = 1'b1;
        wait_busy(1'b0, 20, "iso_busy_fall");
        BtnOp = 3'b111;
        check("iso_flags", 32'(LedFlags), 32'h0);
        read_display(disp);
        check("iso_result", 32'(disp), 32'h11);

        // Reset while in HOLD with exec still held
        SwA = 8'h22; SwB = 8'h11; BtnOp = ~3'd0;
        repeat (12) tick();
        BtnExec = 1'b0;
        wait_busy(1'b1, 20, "mid_busy_rise");
        repeat (5) tick();
        reset = 1'b1;
        repeat (3) tick();
        check("mid_rst_flags", 32'(LedFlags), 32'h4);
        check("mid_rst_digiten", 32'(DigitEn), 32'h2);
        check("mid_rst_seg", 32'(SevenSegResult), 32'h40);
        check("mid_rst_busy", 32'(Busy), 32'h0);
        reset = 1'b0;
        any_busy = 0;
        repeat (30) begin tick(); if (Busy) any_busy++; end
        check("held_through_reset", 32'(any_busy), 32'h0);
        BtnExec = 1'b1;
        repeat (15) tick();
        run_op(8'h81, 8'h00, 3'd5, fl, disp);
        check("shl_flags", 32'(fl), 32'h2);
        check("shl_result", 32'(disp), 32'h02);

        // Digit scan period
        prev_en = DigitEn;
        nchg = 0;
        last_t = 0;
        t = 0;
        while (nchg < 4 && t < 200) begin
            tick();
            t++;
            if (DigitEn !== prev_en) begin
                iv[nchg] = t - last_t;
                last_t = t;
                nchg++;
                prev_en = DigitEn;
            end
        end
        check("scan_changes", 32'(nchg), 32'h4);
        for (int i = 1; i < 4; i++) check($sformatf("scan_interval%0d", i), 32'(iv[i]), 32'd16);

        // Random operations against the reference model
        for (int i = 0; i < 24; i++) begin
            logic [7:0] ra, rb;
            logic [2:0] rop;
            ra  = 8'($urandom_range(0, 255));
            rb  = 8'($urandom_range(0, 255));
            rop = 3'($urandom_range(0, 7));
            exp = model(ra, rb, rop);
            run_op(ra, rb, rop, fl, disp);
            check($sformatf("rnd%0d_flags", i), 32'(fl), 32'(exp[11:8]));
            check($sformatf("rnd%0d_result", i), 32'(disp), 32'(exp[7:0]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_console.md
# alu_console

Parametrised ALU front-end for the lab board. It takes the operand switches, an active-low op-select button bank and an active-low execute button. It debounces the buttons, latches operands on an execute press, computes a registered result with NZCV flags, and drives a time-multiplexed multi-digit active-low seven-segment display in hex. It replaces the single-digit, free-running ALU top with a WIDTH-generic, press-to-execute console.

## Interface
- WIDTH, 8, operand/result width in bits (≥4, multiple of 4)
- DIGITS, WIDTH/4, number of hex display digits
- DEBOUNCE_CYCLES, 4, consecutive stable samples required before a button change is accepted (≥1)
- SCAN_DIV, 16, clock cycles each digit stays enabled (≥1)
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high reset
- SwA  in  WIDTH  operand A switches (asynchronous)
- SwB  in  WIDTH  operand B switches (asynchronous)
- BtnOp  in  3  op-select buttons, active-low (asynchronous)
- BtnExec  in  1  execute button, active-low (asynchronous)
- Busy  out  1  high while in LATCH, EXEC or HOLD
- LedFlags  out  4  {N,Z,C,V} of last executed op
- DigitEn  out  DIGITS  digit enables, active-low, one-hot-low
- SevenSegResult  out  7  segments {g,f,e,d,c,b,a}, active-low

## Operation
- Button path, per button (3 op + exec): 2-FF synchronizer, then a debounce counter. The debounced level updates once the synchronized level has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any mismatch-free cycle resets the counter. Internal op = ~debounced BtnOp; released buttons give op 000.
- Exec event: debounced exec goes released→pressed (rising edge of ~level).
- FSM:
  - IDLE: on exec event → LATCH.
  - LATCH: register SwA, SwB (2-FF synchronized values) and current debounced op → EXEC.
  - EXEC: compute from latched values, register Result and LedFlags → HOLD.
  - HOLD: stay while debounced exec is pressed; on release → IDLE.
- Ops:
  - 000 A+B: C = carry out, V = signed overflow.
  - 001 A−B: C = 1 when A≥B unsigned (no borrow), V = signed overflow.
  - 010 A&B, 011 A|B, 100 A^B: C=V=0.
  - 101 A<<1: C = A[WIDTH-1], V=0.
  - 110 A>>1 (logical): C = A[0], V=0.
  - 111 pass A: C=V=0.
- For every op: N = Result[WIDTH-1], Z = (Result==0). Results are WIDTH bits, modulo 2^WIDTH.
- Display: a scan counter counts 0..SCAN_DIV-1, then advances the digit index 0..DIGITS-1 and wraps to 0. Digit i shows Result[4i+3:4i]; digit 0 is the least-significant nibble. Hex font: 0-9, A, b, C, d, E, F. Segments and enables are registered and inverted at the output.
- Switch changes after LATCH do not affect Result. Op changes after LATCH are ignored.
- An exec event outside IDLE is ignored; a new operation requires release and a new press.

## Timing
- Reset values, applied on the clk edge with reset=1 and held while reset=1:
  - FSM IDLE, Busy=0.
  - Result=0, LedFlags=4'b0100 (Z=1).
  - Debounced levels = released; debounce and scan counters = 0.
  - DigitEn = all ones except bit0 = 0.
  - SevenSegResult = 7'b1000000 ('0').
- Reset mid-operation (LATCH/EXEC/HOLD) aborts to the reset state; a held exec button must be released and re-pressed before a new event.
- Press latency: raw BtnExec low sampled at edge k gives debounced press at edge k+2+DEBOUNCE_CYCLES. LATCH is entered on the next edge and EXEC on the one after. Result/LedFlags update at edge k+DEBOUNCE_CYCLES+5. Busy rises with LATCH.
- A glitch shorter than DEBOUNCE_CYCLES cycles at the synchronizer output produces no event.
- Digit advance: DigitEn changes every SCAN_DIV cycles. The full refresh period is DIGITS·SCAN_DIV cycles. SevenSegResult changes on the same edge as DigitEn.
- A Result update mid-scan is visible from the next digit refresh; there is no blanking.

## Test plan
- Reset, WIDTH=8: hold reset 3 cycles → LedFlags=0100, Result=0, DigitEn=2'b10, SevenSegResult=1000000, Busy=0.
- Add overflow: SwA=0x7F, SwB=0x01, op 000, clean exec press → Result=0x80, flags N=1, Z=0, C=0, V=1, exactly DEBOUNCE_CYCLES+5 cycles after the press; digit1 shows '8', digit0 shows '0'.
- Sub: A=0x05, B=0x05, op 001 → Result=0x00, flags 0110. Then A=0x03, B=0x05 → Result=0xFE, flags 1000.
- Debounce: exec low for DEBOUNCE_CYCLES−1 cycles, then bouncing → no state change. Holding exec 200 cycles → exactly one operation, Busy high until release.
- Latch isolation: after LATCH, change SwA and the op buttons → Result reflects the latched values. A second press while in HOLD is ignored.
- Reset mid-HOLD, then shl: assert reset in HOLD → reset values. Then A=0x81, op 101 → Result=0x02, C=1. Scan check: DigitEn toggles every 16 cycles.
